// File: rtl/shift_load_sequencer.sv
// Serialises a parallel word into the serial-data/mode port of a universal shift register.
// Optional build macro SHIFT_CLEAR_BEFORE_LOAD_EN inserts a register-clearing load cycle before shifting.
//
// purpose : accept a word over valid/ready and drive WIDTH shift commands so the register ends up holding it
// latency : first command one cycle after accept; done pulse WIDTH+1 cycles after accept (+1 with clear)
// backpressure: in_ready is low from accept until the cycle after done (or after an abort)
module shift_load_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic             abort,
  output logic [1:0]       sr_mode,
  output logic             sr_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] word_count
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

  localparam logic [1:0] MODE_LEFT  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LOAD  = 2'b10;
  localparam logic [1:0] MODE_HOLD  = 2'b11;

`ifdef SHIFT_CLEAR_BEFORE_LOAD_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic               dir_q, dir_d;
  logic               in_ready_q, in_ready_d;
  logic [1:0]         sr_mode_q, sr_mode_d;
  logic               sr_data_q, sr_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   word_count_q, word_count_d;

  // MSB-first for left shifts, LSB-first for right shifts.
  function automatic logic pick_bit(input logic [WIDTH-1:0] word,
                                    input logic             dir,
                                    input logic [KW-1:0]    k);
    logic [KW-1:0] idx;
    idx = dir ? k : (K_LAST - k);
    return word[idx];
  endfunction

  function automatic logic [1:0] shift_mode(input logic dir);
    return dir ? MODE_RIGHT : MODE_LEFT;
  endfunction

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    word_d       = word_q;
    dir_d        = dir_q;
    in_ready_d   = 1'b0;
    sr_mode_d    = MODE_HOLD;
    sr_data_d    = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    word_count_d = word_count_q;

    case (state_q)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          word_d     = in_data;
          dir_d      = in_dir;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          k_d        = '0;
`ifdef SHIFT_CLEAR_BEFORE_LOAD_EN
          state_d    = ST_CLEAR;
          sr_mode_d  = MODE_LOAD;
`else
          state_d    = ST_SHIFT;
          sr_mode_d  = shift_mode(in_dir);
          sr_data_d  = pick_bit(in_data, in_dir, '0);
`endif
        end
      end

`ifdef SHIFT_CLEAR_BEFORE_LOAD_EN
      ST_CLEAR: begin
        if (abort) begin
          state_d    = ST_IDLE;
          in_ready_d = 1'b1;
        end else begin
          state_d   = ST_SHIFT;
          busy_d    = 1'b1;
          k_d       = '0;
          sr_mode_d = shift_mode(dir_q);
          sr_data_d = pick_bit(word_q, dir_q, '0);
        end
      end
`endif

      ST_SHIFT: begin
        if (abort) begin
          // Register keeps its partial contents; only the sequencer unwinds.
          state_d    = ST_IDLE;
          in_ready_d = 1'b1;
          k_d        = '0;
        end else if (k_q == K_LAST) begin
          state_d      = ST_DONE;
          done_d       = 1'b1;
          k_d          = '0;
          word_count_d = word_count_q + CNT_W'(1);
        end else begin
          k_d       = k_q + KW'(1);
          busy_d    = 1'b1;
          sr_mode_d = shift_mode(dir_q);
          sr_data_d = pick_bit(word_q, dir_q, k_q + KW'(1));
        end
      end

      ST_DONE: begin
        state_d    = ST_IDLE;
        in_ready_d = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      word_q       <= '0;
      dir_q        <= 1'b0;
      in_ready_q   <= 1'b0;
      sr_mode_q    <= MODE_HOLD;
      sr_data_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      word_q       <= word_d;
      dir_q        <= dir_d;
      in_ready_q   <= in_ready_d;
      sr_mode_q    <= sr_mode_d;
      sr_data_q    <= sr_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      word_count_q <= word_count_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign sr_mode    = sr_mode_q;
  assign sr_data    = sr_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_shift_load_sequencer.sv
// Bench for shift_load_sequencer with a 4-bit universal shift register model downstream.
// Honours SHIFT_CLEAR_BEFORE_LOAD_EN when the design is built with it.
module tb_shift_load_sequencer;

  localparam int W  = 4;
  localparam int CW = 2;
`ifdef SHIFT_CLEAR_BEFORE_LOAD_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_dir;
  logic          abort;
  logic [1:0]    sr_mode;
  logic          sr_data;
  logic          busy;
  logic          done;
  logic [CW-1:0] word_count;

  shift_load_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dir     (in_dir),
    .abort      (abort),
    .sr_mode    (sr_mode),
    .sr_data    (sr_data),
    .busy       (busy),
    .done       (done),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream universal shift register; parallel input tied to zero.
  logic [W-1:0] reg_model;
  always @(posedge clk) begin
    case (sr_mode)
      2'b00:   reg_model <= {reg_model[W-2:0], sr_data};
      2'b01:   reg_model <= {sr_data, reg_model[W-1:1]};
      2'b10:   reg_model <= '0;
      default: reg_model <= reg_model;
    endcase
  end

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  logic [CW-1:0] exp_count;

  logic [2:0]    cmd_q[$];
  logic [CW-1:0] cnt_q[$];
  logic [W-1:0]  word_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_word(input logic [W-1:0] w, input logic d);
    if (EXTRA != 0) cmd_q.push_back(3'b100);
    for (int k = 0; k < W; k++)
      cmd_q.push_back({1'b0, d, d ? w[k] : w[W-1-k]});
    exp_count = exp_count + CW'(1);
    cnt_q.push_back(exp_count);
    word_q.push_back(w);
  endtask

  task automatic run_word(input logic [W-1:0] w, input logic d);
    logic [2:0]    ec;
    logic [CW-1:0] ecnt;
    logic [W-1:0]  ew;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
    else pass_cnt++;
    in_data = w; in_dir = d; in_valid = 1'b1;
    push_word(w, d);
    tick();
    in_valid = 1'b0; in_data = ~w; in_dir = ~d;
    for (int i = 0; i < W + EXTRA; i++) begin
      ec = (cmd_q.size() > 0) ? cmd_q.pop_front() : 3'bxxx;
      total_cnt++;
      if ({sr_mode, sr_data} !== ec)
        $display("FAIL cmd[%0d] word=%b dir=%b: mode/data=%b/%b required %b/%b", i, w, d, sr_mode, sr_data, ec[2:1], ec[0]);
      else pass_cnt++;
      total_cnt++;
      if (busy !== 1'b1 || done !== 1'b0) $display("FAIL busy_in_flight[%0d]: busy=%b done=%b required 1/0", i, busy, done);
      else pass_cnt++;
      tick();
    end
    ecnt = cnt_q.pop_front();
    ew   = word_q.pop_front();
    total_cnt++;
    if (done !== 1'b1 || busy !== 1'b0 || sr_mode !== 2'b11)
      $display("FAIL done_cycle: done=%b busy=%b mode=%b required 1/0/11", done, busy, sr_mode);
    else pass_cnt++;
    total_cnt++;
    if (word_count !== ecnt) $display("FAIL word_count: got %0d required %0d", word_count, ecnt);
    else pass_cnt++;
    total_cnt++;
    if (reg_model !== ew) $display("FAIL register_contents: got %b required %b", reg_model, ew);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done !== 1'b0 || in_ready !== 1'b1) $display("FAIL ready_return: done=%b in_ready=%b required 0/1", done, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_dir = 1'b0; abort = 1'b0;
    repeat (3) tick();
    exp_count = '0;
    total_cnt++;
    if ({in_ready, sr_mode, sr_data, busy, done} !== 6'b011000)
      $display("FAIL reset_outputs: rdy/mode/data/busy/done=%b/%b/%b/%b/%b required 0/11/0/0/0", in_ready, sr_mode, sr_data, busy, done);
    else pass_cnt++;
    total_cnt++;
    if (word_count !== exp_count) $display("FAIL reset_count: got %0d required 0", word_count);
    else pass_cnt++;
    reset = 1'b1;
    tick();
    total_cnt++;
    if (in_ready !== 1'b1 || sr_mode !== 2'b11) $display("FAIL ready_after_reset: in_ready=%b mode=%b required 1/11", in_ready, sr_mode);
    else pass_cnt++;
  endtask

  task automatic test_shift_left();
    run_word(4'b1011, 1'b0);
  endtask

  task automatic test_shift_right();
    run_word(4'b1011, 1'b1);
  endtask

  task automatic test_clear_load();
    reg_model = 4'b1111;
    run_word(4'b0110, 1'b0);
  endtask

  task automatic test_abort();
    in_data = 4'b1011; in_dir = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total_cnt++;
    if (sr_mode !== 2'b11 || sr_data !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0)
      $display("FAIL abort_unwind: mode/data/busy/rdy/done=%b/%b/%b/%b/%b required 11/0/0/1/0", sr_mode, sr_data, busy, in_ready, done);
    else pass_cnt++;
    for (int i = 0; i < W + 2; i++) begin
      total_cnt++;
      if (done !== 1'b0 || word_count !== exp_count)
        $display("FAIL abort_no_done[%0d]: done=%b count=%0d required 0/%0d", i, done, word_count, exp_count);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words [3];
    int acc_cyc [3];
    int n_acc;
    int n_done;
    logic [CW-1:0] ecnt;
    logic [W-1:0]  ew;
    words[0] = 4'b1100; words[1] = 4'b0011; words[2] = 4'b1001;
    n_acc = 0; n_done = 0;
    total_cnt++;
    if (word_count !== exp_count) $display("FAIL b2b_start_count: got %0d required %0d", word_count, exp_count);
    else pass_cnt++;
    in_data = words[0]; in_dir = 1'b0; in_valid = 1'b1;
    for (int t = 0; t < 60 && n_done < 3; t++) begin
      if (in_valid && in_ready) begin
        acc_cyc[n_acc] = cyc;
        push_word(words[n_acc], in_dir);
        n_acc++;
      end
      tick();
      if (n_acc == 3) in_valid = 1'b0;
      else begin
        in_data = words[n_acc];
        in_dir  = n_acc[0];
      end
      if (done === 1'b1) begin
        ecnt = (cnt_q.size() > 0) ? cnt_q.pop_front() : 'x;
        ew   = (word_q.size() > 0) ? word_q.pop_front() : 'x;
        total_cnt++;
        if (word_count !== ecnt) $display("FAIL b2b_count[%0d]: got %0d required %0d", n_done, word_count, ecnt);
        else pass_cnt++;
        total_cnt++;
        if (reg_model !== ew) $display("FAIL b2b_register[%0d]: got %b required %b", n_done, reg_model, ew);
        else pass_cnt++;
        n_done++;
      end
    end
    cmd_q.delete();
    total_cnt++;
    if (n_done != 3 || n_acc != 3) $display("FAIL b2b_completion: accepts=%0d dones=%0d required 3/3", n_acc, n_done);
    else pass_cnt++;
    for (int i = 1; i < 3; i++) begin
      total_cnt++;
      if (i < n_acc && acc_cyc[i] - acc_cyc[i-1] == W + 2 + EXTRA) pass_cnt++;
      else $display("FAIL b2b_interval[%0d]: got %0d required %0d", i, (i < n_acc) ? acc_cyc[i] - acc_cyc[i-1] : -1, W + 2 + EXTRA);
    end
    tick();
  endtask

  task automatic test_reset_mid_shift();
    in_data = 4'b0101; in_dir = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    exp_count = '0;
    total_cnt++;
    if (sr_mode !== 2'b11 || busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_mid_shift: mode/busy/rdy/done=%b/%b/%b/%b required 11/0/0/0", sr_mode, busy, in_ready, done);
    else pass_cnt++;
    total_cnt++;
    if (word_count !== exp_count) $display("FAIL reset_mid_count: got %0d required 0", word_count);
    else pass_cnt++;
    reset = 1'b1;
    tick();
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_mid_ready: in_ready=%b required 1", in_ready);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_shift_left();
    test_shift_right();
    test_abort();
    test_clear_load();
    test_back_to_back();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
